// File: rtl/sdspi_bus_arbiter.sv
// sdspi_bus_arbiter: N-way request/grant switch for the shared SD-card SPI bus with a forced-idle guard between owners
module sdspi_bus_arbiter #(
    parameter int N_MASTERS    = 2,
    parameter int GUARD_CYCLES = 8,
    parameter int RR_MODE      = 0,
    localparam int OW          = (N_MASTERS > 2) ? $clog2(N_MASTERS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] req,
    output logic [N_MASTERS-1:0] grant,
    input  logic [N_MASTERS-1:0] cs_i,
    input  logic [N_MASTERS-1:0] sclk_i,
    input  logic [N_MASTERS-1:0] mosi_i,
    output logic [N_MASTERS-1:0] miso_o,
    output logic                 cs,
    output logic                 sclk,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 busy,
    output logic [OW-1:0]        owner,
    output logic                 abort
);
    typedef enum logic [1:0] {IDLE, GRANTED, GUARD} state_t;
    state_t state, state_d;
    logic [N_MASTERS-1:0] grant_d;
    logic [OW-1:0] owner_d, base, base_d, win;
    logic [OW:0] idx;
    logic [7:0] cnt, cnt_d;
    logic cs_d, sclk_d, mosi_d, abort_d, take, rel, hold;
    assign take   = state == IDLE && |req;
    assign rel    = state == GRANTED && !req[owner];
    assign hold   = state == GRANTED && req[owner];
    assign busy   = state != IDLE;
    assign miso_o = ~grant | {N_MASTERS{miso}};
    // winner: first requester found scanning upward from base with wrap (base stays 0 in fixed priority)
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            idx = {1'b0, base} + (OW+1)'(k);
            idx = idx >= (OW+1)'(N_MASTERS) ? idx - (OW+1)'(N_MASTERS) : idx;
            win = req[idx[OW-1:0]] ? idx[OW-1:0] : win;
        end
    end
    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end
    // next state: ownership only changes through IDLE, never directly between masters
    always_comb begin
        state_d = state == IDLE    ? (|req ? GRANTED : IDLE)
                : state == GRANTED ? (req[owner] ? GRANTED : (GUARD_CYCLES == 0 ? IDLE : GUARD))
                :                    (cnt == 8'd0 ? IDLE : GUARD);
    end
    // next values of the registered outputs; bus is idle everywhere except a held grant
    always_comb begin
        grant_d = take ? N_MASTERS'(1) << win : rel ? '0 : grant;
        owner_d = take ? win : owner;
        cs_d    = hold ? cs_i[owner] : 1'b1;
        sclk_d  = hold & sclk_i[owner];
        mosi_d  = hold ? mosi_i[owner] : 1'b1;
        abort_d = rel & ~cs_i[owner];
        base_d  = (take && RR_MODE != 0) ? (win == OW'(N_MASTERS - 1) ? '0 : win + 1'b1) : base;
        cnt_d   = rel ? 8'(GUARD_CYCLES - 1) : state == GUARD ? cnt - 8'd1 : cnt;
    end
    // output and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant <= '0;
            owner <= '0;
            cs    <= 1'b1;
            sclk  <= 1'b0;
            mosi  <= 1'b1;
            abort <= 1'b0;
            base  <= '0;
            cnt   <= '0;
        end else begin
            grant <= grant_d;
            owner <= owner_d;
            cs    <= cs_d;
            sclk  <= sclk_d;
            mosi  <= mosi_d;
            abort <= abort_d;
            base  <= base_d;
            cnt   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_sdspi_bus_arbiter.sv
// tb_sdspi_bus_arbiter: three arbiter configurations on shared random stimulus, checked against a reference model
module tb_sdspi_bus_arbiter;
    localparam int N = 4;
    logic clk = 0;
    logic rst = 1;
    logic [N-1:0] req = '0, cs_i = '1, sclk_i = '0, mosi_i = '1;
    logic miso = 1;
    logic [N-1:0] grant_o [3];
    logic [N-1:0] miso_v [3];
    logic bus_cs [3], bus_sclk [3], bus_mosi [3], busy_o [3], abort_o [3];
    logic [1:0] owner_o [3];
    int vectors = 0, miscompares = 0;
    int G [3] = '{8, 3, 0};
    bit RR [3] = '{0, 1, 1};
    bit m_own [3], m_cs [3], m_sclk [3], m_mosi [3], m_abort [3];
    int m_owner [3], m_guard [3], m_last [3];
    logic [3:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    always #5 clk = ~clk;

    sdspi_bus_arbiter #(.N_MASTERS(N), .GUARD_CYCLES(8), .RR_MODE(0)) u_a (
        .clk(clk), .rst(rst), .req(req), .grant(grant_o[0]), .cs_i(cs_i), .sclk_i(sclk_i), .mosi_i(mosi_i),
        .miso_o(miso_v[0]), .cs(bus_cs[0]), .sclk(bus_sclk[0]), .mosi(bus_mosi[0]), .miso(miso),
        .busy(busy_o[0]), .owner(owner_o[0]), .abort(abort_o[0]));
    sdspi_bus_arbiter #(.N_MASTERS(N), .GUARD_CYCLES(3), .RR_MODE(1)) u_b (
        .clk(clk), .rst(rst), .req(req), .grant(grant_o[1]), .cs_i(cs_i), .sclk_i(sclk_i), .mosi_i(mosi_i),
        .miso_o(miso_v[1]), .cs(bus_cs[1]), .sclk(bus_sclk[1]), .mosi(bus_mosi[1]), .miso(miso),
        .busy(busy_o[1]), .owner(owner_o[1]), .abort(abort_o[1]));
    sdspi_bus_arbiter #(.N_MASTERS(N), .GUARD_CYCLES(0), .RR_MODE(1)) u_c (
        .clk(clk), .rst(rst), .req(req), .grant(grant_o[2]), .cs_i(cs_i), .sclk_i(sclk_i), .mosi_i(mosi_i),
        .miso_o(miso_v[2]), .cs(bus_cs[2]), .sclk(bus_sclk[2]), .mosi(bus_mosi[2]), .miso(miso),
        .busy(busy_o[2]), .owner(owner_o[2]), .abort(abort_o[2]));

    task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[%0d] @%0t: observed %0h expected %0h", tag, inst, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_own[i] = 0; m_owner[i] = 0; m_guard[i] = 0; m_last[i] = N - 1;
            m_cs[i] = 1; m_sclk[i] = 0; m_mosi[i] = 1; m_abort[i] = 0;
        end
    endtask

    // one clock of the arbitration rules, evaluated on the inputs the DUTs sample at the coming edge
    task automatic model_step();
        int o, start, w;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            m_abort[i] = 0;
            if (m_own[i]) begin
                o = m_owner[i];
                if (!req[o]) begin
                    m_own[i] = 0; m_guard[i] = G[i]; m_abort[i] = !cs_i[o];
                    m_cs[i] = 1; m_sclk[i] = 0; m_mosi[i] = 1;
                end else begin
                    m_cs[i] = cs_i[o]; m_sclk[i] = sclk_i[o]; m_mosi[i] = mosi_i[o];
                end
            end else begin
                m_cs[i] = 1; m_sclk[i] = 0; m_mosi[i] = 1;
                if (m_guard[i] > 0) m_guard[i]--;
                else if (req != 0) begin
                    start = RR[i] ? (m_last[i] + 1) % N : 0;
                    w = -1;
                    for (int k = 0; k < N; k++) if (w < 0 && req[(start + k) % N]) w = (start + k) % N;
                    m_own[i] = 1; m_owner[i] = w; m_last[i] = w;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] eg, em;
        for (int i = 0; i < 3; i++) begin
            eg = m_own[i] ? 4'(1 << m_owner[i]) : 4'b0;
            for (int j = 0; j < N; j++) em[j] = (m_own[i] && m_owner[i] == j) ? miso : 1'b1;
            chk("grant", i, 32'(grant_o[i]), 32'(eg));
            chk("cs", i, 32'(bus_cs[i]), 32'(m_cs[i]));
            chk("sclk", i, 32'(bus_sclk[i]), 32'(m_sclk[i]));
            chk("mosi", i, 32'(bus_mosi[i]), 32'(m_mosi[i]));
            chk("busy", i, 32'(busy_o[i]), 32'(m_own[i] || m_guard[i] > 0));
            chk("abort", i, 32'(abort_o[i]), 32'(m_abort[i]));
            chk("owner", i, 32'(owner_o[i]), 32'(m_owner[i]));
            chk("miso_o", i, 32'(miso_v[i]), 32'(em));
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        cs_i = 4'($urandom); sclk_i = 4'($urandom); mosi_i = 4'($urandom); miso = 1'($urandom);
    endtask

    initial begin
        model_reset();
        #2 rst = 0;
        #1 check_all();
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            chk("rst_grant", i, 32'(grant_o[i]), 32'd0);
            chk("rst_cs", i, 32'(bus_cs[i]), 32'd1);
            chk("rst_busy", i, 32'(busy_o[i]), 32'd0);
        end
        rst = 1;
        // random traffic: level requests that toggle occasionally, random bus activity
        repeat (900) begin
            step();
            for (int b = 0; b < N; b++) if ($urandom_range(11) == 0) req[b] = ~req[b];
        end
        // asynchronous reset while the bus is held low by the owner
        req = 4'b0001;
        for (int c = 0; c < 40 && !(m_own[0] && m_owner[0] == 0); c++) step();
        cs_i = '0;
        step();
        chk("pre_rst_cs", 0, 32'(bus_cs[0]), 32'd0);
        #2 rst = 0;
        #1 model_reset();
        chk("async_cs", 0, 32'(bus_cs[0]), 32'd1);
        chk("async_grant", 0, 32'(grant_o[0]), 32'd0);
        check_all();
        step();
        rst = 1;
        step();
        chk("regrant", 0, 32'(grant_o[0]), 32'b0001);
        // fixed priority picks the lowest index again after a release; round-robin moves on
        rst = 0; req = 4'b1010;
        step();
        rst = 1;
        step();
        chk("fp_first", 0, 32'(grant_o[0]), 32'b0010);
        req = 4'b1000;
        step();
        req = 4'b1010;
        repeat (12) step();
        chk("fp_again", 0, 32'(grant_o[0]), 32'b0010);
        chk("rr_next", 1, 32'(grant_o[1]), 32'b1000);
        chk("rr_g0_next", 2, 32'(grant_o[2]), 32'b1000);
        // round-robin rotation with every master requesting
        rst = 0; req = 4'b1111;
        step();
        rst = 1;
        for (int it = 0; it < 5; it++) begin
            for (int c = 0; c < 30 && grant_o[1] == 0; c++) step();
            chk("rr_seq", 1, 32'(grant_o[1]), 32'(rr_seq[it]));
            repeat (20) step();
            req[m_owner[1]] = 0;
            step();
            req = 4'b1111;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
